// File: rtl/dpsram_bank.sv
// dpsram_bank: simple dual-port SRAM bank (1W/1R), byte-masked writes,
// read latency 1 or 2 with RVALID strobe, and a one-word-per-cycle clear
// sequencer that replaces an array-wide reset and can be re-run via CLR.
// Ports: CLK, RSTN (async active-low), WE/WADDR/WDATA/WMASK write port,
// RE/RADDR read request, RDATA/RVALID read result, CLR re-clear request,
// INIT_DONE array usable.
// Optional macro DPSRAM_WR_FWD_EN: same-cycle same-address write/read
// returns the merged (write-first) word; otherwise read-first.
module dpsram_bank #(
  parameter int                    BITWIDTH = 32,
  parameter int                    DEPTH    = 8,
  parameter int                    RD_LAT   = 1,
  parameter logic [BITWIDTH-1:0]   INIT_VAL = '0
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     WE,
  input  logic [DEPTH-1:0]         WADDR,
  input  logic [BITWIDTH-1:0]      WDATA,
  input  logic [BITWIDTH/8-1:0]    WMASK,
  input  logic                     RE,
  input  logic [DEPTH-1:0]         RADDR,
  output logic [BITWIDTH-1:0]      RDATA,
  output logic                     RVALID,
  input  logic                     CLR,
  output logic                     INIT_DONE
);

  localparam int NB    = BITWIDTH / 8;
  localparam int WORDS = 1 << DEPTH;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("dpsram_bank: RD_LAT must be 1 or 2");
  end
  if (BITWIDTH % 8 != 0) begin : g_bad_width
    $error("dpsram_bank: BITWIDTH must be a multiple of 8");
  end

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t               state;
  logic [DEPTH-1:0]     cnt;
  logic [BITWIDTH-1:0]  mem [WORDS];
  logic [BITWIDTH-1:0]  rd_word;
  logic                 clr_act;
  logic                 wr_act;
  logic                 rd_act;

  assign clr_act = (state == S_CLEAR);
  assign wr_act  = WE && (state == S_READY);
  assign rd_act  = RE && (state == S_READY);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_CLEAR;
      cnt       <= '0;
      INIT_DONE <= 1'b0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state     <= S_READY;
            INIT_DONE <= 1'b1;
          end
        end
        S_READY: begin
          if (CLR) begin
            state     <= S_CLEAR;
            cnt       <= '0;
            INIT_DONE <= 1'b0;
          end
        end
        default: begin
          state     <= S_CLEAR;
          cnt       <= '0;
          INIT_DONE <= 1'b0;
        end
      endcase
    end
  end

  // No reset branch: the array must map onto a macro.
  always_ff @(posedge CLK) begin
    if (clr_act) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr_act) begin
      for (int b = 0; b < NB; b++) begin
        if (WMASK[b]) begin
          mem[WADDR][8*b +: 8] <= WDATA[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[RADDR];
`ifdef DPSRAM_WR_FWD_EN
    if (wr_act && (WADDR == RADDR)) begin
      for (int b = 0; b < NB; b++) begin
        if (WMASK[b]) begin
          rd_word[8*b +: 8] = WDATA[8*b +: 8];
        end
      end
    end
`endif
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [BITWIDTH-1:0] s_data;
    logic                s_vld;

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        s_data <= '0;
        s_vld  <= 1'b0;
        RDATA  <= '0;
        RVALID <= 1'b0;
      end else begin
        s_vld  <= rd_act;
        if (rd_act) begin
          s_data <= rd_word;
        end
        RVALID <= s_vld;
        if (s_vld) begin
          RDATA <= s_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        RDATA  <= '0;
        RVALID <= 1'b0;
      end else begin
        RVALID <= rd_act;
        if (rd_act) begin
          RDATA <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpsram_bank.sv
// tb_dpsram_bank: directed bench for dpsram_bank, RD_LAT=1 and RD_LAT=2
// instances driven by the same stimulus, DEPTH=4, INIT_VAL=A5A5A5A5.
module tb_dpsram_bank;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        WE = 1'b0;
  logic [3:0]  WADDR = '0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WMASK = '0;
  logic        RE = 1'b0;
  logic [3:0]  RADDR = '0;
  logic        CLR = 1'b0;

  logic [31:0] rdata1, rdata2;
  logic        rvalid1, rvalid2;
  logic        done1, done2;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] IV = 32'hA5A5A5A5;

  always #5 CLK = ~CLK;

  dpsram_bank #(
    .BITWIDTH(32), .DEPTH(4), .RD_LAT(1), .INIT_VAL(IV)
  ) u_l1 (
    .CLK(CLK), .RSTN(RSTN),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .WMASK(WMASK),
    .RE(RE), .RADDR(RADDR),
    .RDATA(rdata1), .RVALID(rvalid1),
    .CLR(CLR), .INIT_DONE(done1)
  );

  dpsram_bank #(
    .BITWIDTH(32), .DEPTH(4), .RD_LAT(2), .INIT_VAL(IV)
  ) u_l2 (
    .CLK(CLK), .RSTN(RSTN),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .WMASK(WMASK),
    .RE(RE), .RADDR(RADDR),
    .RDATA(rdata2), .RVALID(rvalid2),
    .CLR(CLR), .INIT_DONE(done2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] m);
    WE = 1'b1; WADDR = a; WDATA = d; WMASK = m;
    step();
    WE = 1'b0;
  endtask

  // Any write set up by the caller happens in the same cycle as the read.
  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [31:0] exp);
    RE = 1'b1; RADDR = a;
    step();
    RE = 1'b0; WE = 1'b0;
    check({tag, "_v1"}, 32'(rvalid1), 32'd1);
    check({tag, "_d1"}, rdata1, exp);
    check({tag, "_e2"}, 32'(rvalid2), 32'd0);
    step();
    check({tag, "_v2"}, 32'(rvalid2), 32'd1);
    check({tag, "_d2"}, rdata2, exp);
    check({tag, "_e1"}, 32'(rvalid1), 32'd0);
  endtask

  // Counts edges until INIT_DONE rises; drops WE/RE as soon as it does.
  task automatic wait_init(output int n, output logic saw_v);
    n = 0;
    saw_v = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rvalid1 || rvalid2) saw_v = 1'b1;
      if (done1) begin
        n = i;
        WE = 1'b0;
        RE = 1'b0;
        break;
      end
    end
  endtask

  int          n;
  logic        sv;
  logic [31:0] e;

  initial begin
    step();
    step();
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    RSTN = 1'b1;
    wait_init(n, sv);
    check("clr_cycles", n, 32'd16);
    check("clr_done2", 32'(done2), 32'd1);
    rd("init_a0", 4'd0, IV);
    rd("init_a15", 4'd15, IV);

    wr(4'd3, 32'h11223344, 4'b1111);
    wr(4'd3, 32'hFFFFFFFF, 4'b0101);
    rd("mask", 4'd3, 32'h11FF33FF);
    wr(4'd3, 32'h00000000, 4'b0000);
    rd("mask0", 4'd3, 32'h11FF33FF);

    wr(4'd1, 32'h00000101, 4'hF);
    wr(4'd2, 32'h00000202, 4'hF);
    wr(4'd3, 32'h00000303, 4'hF);
    RE = 1'b1; RADDR = 4'd1;
    step();
    check("b2b_v1a", 32'(rvalid1), 32'd1);
    check("b2b_d1a", rdata1, 32'h101);
    check("b2b_v2a", 32'(rvalid2), 32'd0);
    RADDR = 4'd2;
    step();
    check("b2b_d1b", rdata1, 32'h202);
    check("b2b_v2b", 32'(rvalid2), 32'd1);
    check("b2b_d2b", rdata2, 32'h101);
    RADDR = 4'd3;
    step();
    RE = 1'b0;
    check("b2b_d1c", rdata1, 32'h303);
    check("b2b_v2c", 32'(rvalid2), 32'd1);
    check("b2b_d2c", rdata2, 32'h202);
    step();
    check("b2b_v1d", 32'(rvalid1), 32'd0);
    check("b2b_v2d", 32'(rvalid2), 32'd1);
    check("b2b_d2d", rdata2, 32'h303);
    step();
    check("b2b_v2e", 32'(rvalid2), 32'd0);
    check("b2b_hold1", rdata1, 32'h303);
    check("b2b_hold2", rdata2, 32'h303);

    wr(4'd9, 32'h0, 4'hF);
`ifdef DPSRAM_WR_FWD_EN
    e = 32'hDEADBEEF;
`else
    e = 32'h0;
`endif
    WE = 1'b1; WADDR = 4'd9; WDATA = 32'hDEADBEEF; WMASK = 4'hF;
    rd("coll", 4'd9, e);
    rd("coll_after", 4'd9, 32'hDEADBEEF);
`ifdef DPSRAM_WR_FWD_EN
    e = 32'hDEAD1111;
`else
    e = 32'hDEADBEEF;
`endif
    WE = 1'b1; WADDR = 4'd9; WDATA = 32'h11111111; WMASK = 4'b0011;
    rd("coll_part", 4'd9, e);
    WE = 1'b1; WADDR = 4'd10; WDATA = 32'hCAFEF00D; WMASK = 4'hF;
    rd("diff_addr", 4'd9, 32'hDEAD1111);
    rd("diff_wr", 4'd10, 32'hCAFEF00D);

    wr(4'd7, 32'h5, 4'hF);
    rd("a7_pre", 4'd7, 32'h5);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("reclr_drop", 32'(done1), 32'd0);
    WE = 1'b1; WADDR = 4'd7; WDATA = 32'h77; WMASK = 4'hF;
    RE = 1'b1; RADDR = 4'd7;
    wait_init(n, sv);
    check("reclr_cycles", n, 32'd16);
    check("reclr_novalid", 32'(sv), 32'd0);
    rd("reclr_a7", 4'd7, IV);

    CLR = 1'b1;
    step();
    CLR = 1'b0;
    for (int i = 0; i < 5; i++) step();
    RSTN = 1'b0;
    #1;
    check("mid_rdata1", rdata1, 32'h0);
    check("mid_rdata2", rdata2, 32'h0);
    check("mid_rvalid2", 32'(rvalid2), 32'd0);
    check("mid_done1", 32'(done1), 32'd0);
    step();
    RSTN = 1'b1;
    wait_init(n, sv);
    check("mid_cycles", n, 32'd16);
    rd("mid_a15", 4'd15, IV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
